// File: rtl/call_return_stack.sv
// Return-address stack feeding the PC mux: PUSH saves PC_COUNT+1, POP discards the top.
// Optional high-water-mark output HWM is enabled by defining CALL_STACK_HWM_EN.
module call_return_stack #(
  parameter int DEPTH = 16,
  parameter int AW    = 10,
  localparam int SW   = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] PC_COUNT,
  input  logic          PUSH,
  input  logic          POP,
  input  logic          ERR_CLR,
  output logic [AW-1:0] FROM_STACK,
  output logic [SW-1:0] SP,
  output logic          EMPTY,
  output logic          FULL,
  output logic          OVF,
  output logic          UNF
`ifdef CALL_STACK_HWM_EN
  ,
  output logic [SW-1:0] HWM
`endif
);

  localparam int IW = $clog2(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [SW-1:0] sp_q, sp_d;
  logic          ovf_q, unf_q;
  logic          ovf_set, unf_set;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic [AW-1:0] pc_inc;
  logic          empty, full;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SW'(DEPTH));
  assign top_idx = IW'(sp_q - SW'(1));
  assign pc_inc  = PC_COUNT + AW'(1);

  assign FROM_STACK = empty ? '0 : mem[top_idx];
  assign SP         = sp_q;
  assign EMPTY      = empty;
  assign FULL       = full;
  assign OVF        = ovf_q;
  assign UNF        = unf_q;

  always_comb begin
    sp_d    = sp_q;
    wr_en   = 1'b0;
    wr_idx  = IW'(sp_q);
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case ({PUSH, POP})
      2'b10: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          wr_en = 1'b1;
          sp_d  = sp_q + SW'(1);
        end
      end
      2'b01: begin
        if (empty) unf_set = 1'b1;
        else       sp_d    = sp_q - SW'(1);
      end
      2'b11: begin
        // Simultaneous push+pop replaces the top; on an empty stack it degrades to a push.
        wr_en = 1'b1;
        if (empty) begin
          wr_idx  = '0;
          sp_d    = SW'(1);
          unf_set = 1'b1;
        end else begin
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_set | (ovf_q & ~ERR_CLR);
      unf_q <= unf_set | (unf_q & ~ERR_CLR);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_idx] <= pc_inc;
  end

`ifdef CALL_STACK_HWM_EN
  logic [SW-1:0] hwm_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)               hwm_q <= '0;
    else if (sp_d > hwm_q) hwm_q <= sp_d;
  end

  assign HWM = hwm_q;
`endif

endmodule
